// File: rtl/ranger_pkg.sv
// rtl/ranger_pkg.sv - shared direction encodings, FSM states and playfield limits
package ranger_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAYER = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  // Step size and playfield limits shared with the sprite mover
  localparam int PF_STEP  = 5;
  localparam int PF_H_MIN = 0;
  localparam int PF_H_MAX = 630;
  localparam int PF_V_MIN = 0;
  localparam int PF_V_MAX = 470;

  // True when exactly one of the four direction bits is set
  function automatic logic dir_onehot(input logic [3:0] d);
    return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick every DIV clocks
module tick_gen #(
  parameter int DIV = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..DIV-1 and wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ranger_move_ctrl.sv
// rtl/ranger_move_ctrl.sv - tick-paced move arbiter between player buttons and autopilot
module ranger_move_ctrl
  import ranger_pkg::*;
#(
  parameter int STEP       = PF_STEP,
  parameter int TICK_DIV   = 833333,
  parameter int HOLD_TICKS = 8,
  parameter int H_MIN      = PF_H_MIN,
  parameter int H_MAX      = PF_H_MAX,
  parameter int V_MIN      = PF_V_MIN,
  parameter int V_MAX      = PF_V_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [3:0]  auto_dir,
  input  logic        auto_valid,
  output logic        auto_ready,
  input  logic [19:0] position,
  output logic [3:0]  move,
  output logic        owner,
  output logic        blocked
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

  // 11-bit limits so position + STEP never wraps
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] UP_LIM  = 11'(V_MIN + STEP);
  localparam logic [10:0] DN_LIM  = 11'(V_MAX);
  localparam logic [10:0] LT_LIM  = 11'(H_MIN + STEP);
  localparam logic [10:0] RT_LIM  = 11'(H_MAX);

  logic          tick;
  state_t        state, next_state;
  logic [HW-1:0] idle_cnt, idle_next;
  logic [3:0]    player_dir, auto_sel, sel;
  logic          sel_blocked;
  logic [10:0]   hpos, vpos;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign hpos = {1'b0, position[19:10]};
  assign vpos = {1'b0, position[9:0]};

  // Player request reduced to one-hot, up > down > left > right
  always_comb begin
    player_dir = DIR_NONE;
    if (btn[3])      player_dir = DIR_UP;
    else if (btn[2]) player_dir = DIR_DOWN;
    else if (btn[1]) player_dir = DIR_LEFT;
    else if (btn[0]) player_dir = DIR_RIGHT;
  end

  // Malformed autopilot offers still get consumed but never move the sprite
  assign auto_sel = dir_onehot(auto_dir) ? auto_dir : DIR_NONE;

  // Next state, idle hold counter, selected direction and autopilot handshake
  always_comb begin
    next_state = state;
    idle_next  = idle_cnt;
    sel        = DIR_NONE;
    auto_ready = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (player_dir != DIR_NONE) begin
            next_state = ST_PLAYER;
            sel        = player_dir;
            idle_next  = '0;
          end else if (auto_valid) begin
            next_state = ST_AUTO;
            sel        = auto_sel;
            auto_ready = 1'b1;
          end
        end
        ST_PLAYER: begin
          if (player_dir != DIR_NONE) begin
            sel       = player_dir;
            idle_next = '0;
          end else if (idle_cnt + HW'(1) >= HOLD_LAST) begin
            next_state = ST_IDLE;
            idle_next  = '0;
          end else begin
            idle_next = idle_cnt + HW'(1);
          end
        end
        ST_AUTO: begin
          if (player_dir != DIR_NONE) begin
            next_state = ST_PLAYER;
            sel        = player_dir;
            idle_next  = '0;
          end else if (auto_valid) begin
            sel        = auto_sel;
            auto_ready = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
        default: begin
          next_state = ST_IDLE;
          idle_next  = '0;
        end
      endcase
    end
  end

  // Suppress any step that would carry the sprite past a playfield edge
  always_comb begin
    sel_blocked = 1'b0;
    case (sel)
      DIR_UP:    sel_blocked = (vpos < UP_LIM);
      DIR_DOWN:  sel_blocked = (vpos + STEP11 > DN_LIM);
      DIR_LEFT:  sel_blocked = (hpos < LT_LIM);
      DIR_RIGHT: sel_blocked = (hpos + STEP11 > RT_LIM);
      default:   sel_blocked = 1'b0;
    endcase
  end

  // State and idle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= next_state;
      idle_cnt <= idle_next;
    end
  end

  // Registered command outputs; move and blocked are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move    <= DIR_NONE;
      blocked <= 1'b0;
      owner   <= 1'b0;
    end else if (tick) begin
      move    <= sel_blocked ? DIR_NONE : sel;
      blocked <= sel_blocked;
      owner   <= (next_state == ST_AUTO);
    end else begin
      move    <= DIR_NONE;
      blocked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ranger_move_ctrl.sv
// tb/tb_ranger_move_ctrl.sv - scoreboard bench for ranger_move_ctrl
module tb_ranger_move_ctrl;

  localparam int TICK_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  btn;
  logic [3:0]  auto_dir;
  logic        auto_valid;
  logic        auto_ready;
  logic [19:0] position;
  logic [3:0]  move;
  logic        owner;
  logic        blocked;

  typedef struct packed {
    logic       ready;
    logic [3:0] mv;
    logic       own;
    logic       blk;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic have_cur;
  logic mon_en;
  int   checks;
  int   errors;
  int   cnt;

  ranger_move_ctrl #(
    .STEP(5), .TICK_DIV(TICK_DIV), .HOLD_TICKS(2),
    .H_MIN(0), .H_MAX(630), .V_MIN(0), .V_MAX(470)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .auto_dir   (auto_dir),
    .auto_valid (auto_valid),
    .auto_ready (auto_ready),
    .position   (position),
    .move       (move),
    .owner      (owner),
    .blocked    (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle position within the tick period; 3 is the tick cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else        cnt <= (cnt + 1) % TICK_DIV;
  end

  // Scoreboard monitor: ready checked in the tick cycle, outputs one cycle later
  always @(negedge clk) begin
    if (mon_en) begin
      if (cnt == TICK_DIV - 1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: no expectation queued at t=%0t", $time);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          checks++;
          if (auto_ready !== cur.ready) begin
            errors++;
            $display("FAIL auto_ready_tick: got %b want %b t=%0t", auto_ready, cur.ready, $time);
          end
        end
      end else begin
        checks++;
        if (auto_ready !== 1'b0) begin
          errors++;
          $display("FAIL auto_ready_off_tick: got %b want 0 t=%0t", auto_ready, $time);
        end
      end
      if (cnt == 0 && have_cur) begin
        have_cur = 1'b0;
        checks++;
        if (move !== cur.mv) begin
          errors++;
          $display("FAIL move: got %b want %b t=%0t", move, cur.mv, $time);
        end
        checks++;
        if (owner !== cur.own) begin
          errors++;
          $display("FAIL owner: got %b want %b t=%0t", owner, cur.own, $time);
        end
        checks++;
        if (blocked !== cur.blk) begin
          errors++;
          $display("FAIL blocked: got %b want %b t=%0t", blocked, cur.blk, $time);
        end
      end else begin
        checks++;
        if (move !== 4'b0000 || blocked !== 1'b0) begin
          errors++;
          $display("FAIL idle_cycle_pulse: move %b blocked %b want 0/0 t=%0t", move, blocked, $time);
        end
      end
    end
  end

  // Drive one tick period of stimulus and queue its expected outcome
  task automatic run_tick(input logic [3:0] b, input logic av, input logic [3:0] ad,
                          input int h, input int v,
                          input logic er, input logic [3:0] em, input logic eo, input logic eb);
    int guard;
    exp_t e;
    guard = 0;
    while (cnt != 1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    btn        = b;
    auto_valid = av;
    auto_dir   = ad;
    position   = {h[9:0], v[9:0]};
    e.ready = er; e.mv = em; e.own = eo; e.blk = eb;
    q.push_back(e);
    mon_en = 1'b1;
    @(negedge clk);
    guard = 0;
    while (cnt != 1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    btn = 4'b0; auto_valid = 1'b0; auto_dir = 4'b0; position = {10'd263, 10'd170};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (move !== 4'b0 || owner !== 1'b0 || blocked !== 1'b0 || auto_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: move %b owner %b blocked %b ready %b want all 0", move, owner, blocked, auto_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (move !== 4'b0 || owner !== 1'b0 || blocked !== 1'b0 || auto_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: cycle %0d move %b owner %b blocked %b ready %b want all 0",
                 i, move, owner, blocked, auto_ready);
      end
    end
  endtask

  task automatic test_player_hold();
    for (int i = 0; i < 3; i++)
      run_tick(4'b0001, 1'b0, 4'b0, 263, 170, 1'b0, 4'b0001, 1'b0, 1'b0);
  endtask

  task automatic test_priority_release();
    run_tick(4'b1010, 1'b0, 4'b0, 263, 170, 1'b0, 4'b1000, 1'b0, 1'b0);
    run_tick(4'b0000, 1'b1, 4'b0100, 263, 170, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_tick(4'b0000, 1'b1, 4'b0100, 263, 170, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_tick(4'b0000, 1'b1, 4'b0100, 263, 170, 1'b1, 4'b0100, 1'b1, 1'b0);
  endtask

  task automatic test_auto_preempt();
    run_tick(4'b0000, 1'b1, 4'b0100, 263, 175, 1'b1, 4'b0100, 1'b1, 1'b0);
    run_tick(4'b0000, 1'b1, 4'b0100, 263, 180, 1'b1, 4'b0100, 1'b1, 1'b0);
    run_tick(4'b1000, 1'b1, 4'b0100, 263, 185, 1'b0, 4'b1000, 1'b0, 1'b0);
  endtask

  task automatic test_bounds();
    run_tick(4'b1000, 1'b0, 4'b0, 263, 3,   1'b0, 4'b0000, 1'b0, 1'b1);
    run_tick(4'b1000, 1'b0, 4'b0, 263, 5,   1'b0, 4'b1000, 1'b0, 1'b0);
    run_tick(4'b0001, 1'b0, 4'b0, 625, 170, 1'b0, 4'b0001, 1'b0, 1'b0);
    run_tick(4'b0001, 1'b0, 4'b0, 626, 170, 1'b0, 4'b0000, 1'b0, 1'b1);
    run_tick(4'b0100, 1'b0, 4'b0, 263, 465, 1'b0, 4'b0100, 1'b0, 1'b0);
    run_tick(4'b0100, 1'b0, 4'b0, 263, 466, 1'b0, 4'b0000, 1'b0, 1'b1);
    run_tick(4'b0010, 1'b0, 4'b0, 5,   170, 1'b0, 4'b0010, 1'b0, 1'b0);
    run_tick(4'b0010, 1'b0, 4'b0, 4,   170, 1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_auto_edge_cases();
    run_tick(4'b0000, 1'b0, 4'b0,    263, 170, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_tick(4'b0000, 1'b0, 4'b0,    263, 170, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_tick(4'b0000, 1'b1, 4'b0110, 263, 170, 1'b1, 4'b0000, 1'b1, 1'b0);
    run_tick(4'b0000, 1'b0, 4'b0,    263, 170, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_tick(4'b0000, 1'b1, 4'b0000, 263, 170, 1'b1, 4'b0000, 1'b1, 1'b0);
    run_tick(4'b0000, 1'b1, 4'b1000, 263, 3,   1'b1, 4'b0000, 1'b1, 1'b1);
    run_tick(4'b0000, 1'b1, 4'b0001, 263, 3,   1'b1, 4'b0001, 1'b1, 1'b0);
    run_tick(4'b0000, 1'b0, 4'b0,    263, 3,   1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    int guard;
    int cyc;
    mon_en = 1'b0;
    btn = 4'b0001; auto_valid = 1'b0; position = {10'd263, 10'd170};
    guard = 0;
    while (move !== 4'b0001 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (move !== 4'b0001) begin
      errors++;
      $display("FAIL async_wait_move: got %b want 0001 within 20 cycles", move);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (move !== 4'b0 || owner !== 1'b0 || blocked !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop: move %b owner %b blocked %b want 0", move, owner, blocked);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 1;
    while (move === 4'b0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != TICK_DIV + 1 || move !== 4'b0001) begin
      errors++;
      $display("FAIL async_first_move: seen in cycle %0d move %b want cycle %0d move 0001",
               cyc, move, TICK_DIV + 1);
    end
    btn = 4'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    have_cur = 1'b0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    btn = 4'b0; auto_valid = 1'b0; auto_dir = 4'b0; position = '0;
    test_reset();
    test_player_hold();
    test_priority_release();
    test_auto_preempt();
    test_bounds();
    test_auto_edge_cases();
    test_async_reset();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
